// File: rtl/spike_fire_unit_if.sv
// rtl/spike_fire_unit_if.sv - spike event stream toward the router
// Master drives the FIFO head; slave applies backpressure via spike_ready.
interface spike_fire_unit_if #(
   parameter int TS_W = 12
);
   logic                spike_valid;
   logic                spike_ready;
   logic [8+TS_W-1:0]   spike_data;

   modport master (
      output spike_valid,
      output spike_data,
      input  spike_ready
   );

   modport slave (
      input  spike_valid,
      input  spike_data,
      output spike_ready
   );
endinterface

// File: rtl/spike_fire_unit.sv
// rtl/spike_fire_unit.sv - threshold compare, refractory clamp and spike event FIFO
// Closes the integrate-and-fire loop and emits {neuron_id, timestamp} events.
module spike_fire_unit #(
   parameter int NEURON_ID  = 0,
   parameter int TS_W       = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         membrane_in,
   input  logic               membrane_valid,
   input  logic [7:0]         threshold,
   input  logic [1:0]         reset_mode,
   input  logic [7:0]         reset_const,
   input  logic [3:0]         refract_len,
   input  logic               tick,
   output logic               spike_detected,
   output logic [7:0]         reset_value,
   output logic [7:0]         drop_count,
   output logic               refractory,
   spike_fire_unit_if.master  spike_if
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = 8 + TS_W;

   typedef enum logic {ARMED, REFRACT} state_e;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [TS_W-1:0] ts_q, ts_d;
   logic            spike_det_q, spike_det_d;
   logic            refractory_q, refractory_d;
   logic [7:0]      reset_val_q, reset_val_d;
   logic [7:0]      drop_q, drop_d;
   logic [DW-1:0]   mem_q [FIFO_DEPTH];
   logic [DW-1:0]   mem_d [FIFO_DEPTH];
   logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
   logic            fire, empty, full, push, pop;

   assign fire  = (state_q == ARMED) && membrane_valid && (threshold != 8'd0) &&
                  (membrane_in >= threshold);
   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop   = !empty && spike_if.spike_ready;
   // A pop in the same cycle frees the slot, so a fire into a full FIFO still lands.
   assign push  = fire && (!full || pop);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      spike_det_d  = 1'b0;
      refractory_d = 1'b0;
      reset_val_d  = reset_val_q;
      case (state_q)
         ARMED: begin
            if (fire) begin
               spike_det_d = 1'b1;
               case (reset_mode)
                  2'd1:    reset_val_d = membrane_in - threshold;
                  2'd2:    reset_val_d = membrane_in;
                  default: reset_val_d = reset_const;
               endcase
               if (refract_len != 4'd0) begin
                  state_d = REFRACT;
                  cnt_d   = refract_len;
               end
            end
         end
         REFRACT: begin
            // Keep clamping the integrator with the value loaded at the fire.
            spike_det_d  = 1'b1;
            refractory_d = 1'b1;
            cnt_d        = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ARMED;
            end
         end
         default: state_d = ARMED;
      endcase
   end

   always_comb begin
      ts_d = tick ? ts_q + TS_W'(1) : ts_q;
      mem_d  = mem_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      drop_d = drop_q;
      if (push) begin
         mem_d[wr_q[AW-1:0]] = {8'(NEURON_ID), ts_q};
         wr_d                = wr_q + (AW+1)'(1);
      end
      if (pop) begin
         rd_d = rd_q + (AW+1)'(1);
      end
      if (fire && !push && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARMED;
         cnt_q        <= 4'd0;
         ts_q         <= '0;
         spike_det_q  <= 1'b0;
         refractory_q <= 1'b0;
         reset_val_q  <= 8'd0;
         drop_q       <= 8'd0;
         wr_q         <= '0;
         rd_q         <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ts_q         <= ts_d;
         spike_det_q  <= spike_det_d;
         refractory_q <= refractory_d;
         reset_val_q  <= reset_val_d;
         drop_q       <= drop_d;
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         mem_q        <= mem_d;
      end
   end

   assign spike_detected       = spike_det_q;
   assign reset_value          = reset_val_q;
   assign drop_count           = drop_q;
   assign refractory           = refractory_q;
   assign spike_if.spike_valid = !empty;
   assign spike_if.spike_data  = empty ? '0 : mem_q[rd_q[AW-1:0]];
endmodule

// File: doc/spike_fire_unit.md
Name: spike_fire_unit

Overview:
- Firing stage paired with the per-neuron integrator, consuming the integrator's membrane value.
- Compares the membrane with a programmable threshold and drives the integrator's spike_detected / reset_value inputs, which closes the integrate-and-fire loop.
- Enforces a refractory period.
- Queues spike events (neuron id + timestamp) in a small FIFO toward the spike router over a valid/ready interface.

Parameters:
- NEURON_ID, 0, fixed id stamped into every spike event (8 bits).
- TS_W, 12, timestamp counter width.
- FIFO_DEPTH, 4, spike event FIFO entries (power of 2, >= 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- membrane_in  in  8  membrane value from integrator (unsigned)
- membrane_valid  in  1  membrane_in is a fresh post-integration sample
- threshold  in  8  firing threshold (unsigned); 0 disables firing
- reset_mode  in  2  0: reset to reset_const; 1: subtract threshold; 2: hold (no reset); 3: same as 0
- reset_const  in  8  reset constant for modes 0/3
- refract_len  in  4  refractory cycles after a fire (0 = none)
- tick  in  1  global time-step pulse
- spike_detected  out  1  to integrator: load reset_value this cycle
- reset_value  out  8  to integrator
- spike_valid  out  1  FIFO head valid
- spike_ready  in  1  router accepts head
- spike_data  out  8+TS_W  {neuron_id[7:0], timestamp[TS_W-1:0]}
- drop_count  out  8  saturating count of events dropped on FIFO full
- refractory  out  1  high while in REFRACT

Behaviour:
- Reset values: all outputs 0; state ARMED; FIFO empty; timestamp 0; refract counter 0.
- Timestamp: increments by 1 on each tick and wraps to 0 at 2^TS_W. The value sampled at the fire cycle is the value before the same-cycle tick increment.
- States: ARMED, REFRACT.
- ARMED, cycle N: membrane_valid=1, threshold!=0 and membrane_in >= threshold constitutes a fire. Then in cycle N+1:
  - spike_detected=1 for exactly one cycle.
  - reset_value = reset_const (modes 0/3), membrane_in - threshold (mode 1, never underflows), or membrane_in (mode 2).
  - Event pushed into the FIFO.
  - State moves to REFRACT if refract_len!=0, else stays ARMED.
- Latency: one cycle from sample to spike_detected.
- No fire in ARMED: spike_detected=0, reset_value holds its last value. membrane_valid=0 is ignored.
- Fires from consecutive membrane_valid cycles are allowed while ARMED with refract_len=0, one fire per sample.
- REFRACT:
  - Counter loads refract_len at the fire cycle and decrements each cycle.
  - refractory=1 in every REFRACT cycle.
  - spike_detected=1 with reset_value unchanged each REFRACT cycle after the fire pulse, clamping the integrator.
  - No compare and no events are generated.
  - State returns to ARMED when the counter reaches 0. Total refractory cycles after the fire cycle = refract_len.
- Config (threshold, reset_mode, reset_const, refract_len) is sampled at the compare cycle. Mid-refractory changes do not alter the current period.
- FIFO behaviour:
  - First-word fall-through.
  - spike_valid = !empty; spike_data = head.
  - Pop when spike_valid && spike_ready.
  - Push on fire. Simultaneous push+pop when full is legal: the pop frees the slot and the push succeeds.
  - Push when full with no pop: event dropped, drop_count +1, saturating at 255.
  - spike_data must stay stable while spike_valid && !spike_ready.
- rst mid-operation: immediate return to reset values. In-flight FIFO contents are discarded; drop_count and timestamp clear.

Test Plan:
- Basic fire:
  - Stimulus: threshold=100, mode 0, reset_const=5, refract_len=0; membrane_in=99 then 100, each with valid.
  - Required: no fire on 99. On 100, spike_detected pulses one cycle after the sample with reset_value=5, and spike_data={NEURON_ID, ts} appears with spike_valid next cycle.
- Subtract and hold modes:
  - Mode 1, threshold=100, membrane_in=130 -> reset_value=30.
  - Mode 2, membrane_in=200 -> reset_value=200.
  - threshold=0, membrane_in=255 -> never fires.
- Refractory:
  - Stimulus: refract_len=3, membrane_in=200 every cycle with valid.
  - Required: fire pulse followed by 3 cycles of spike_detected=1 with refractory=1. Next fire occurs on the first ARMED sample (4 cycles between fire pulses); exactly one event per fire.
- Backpressure/overflow:
  - Stimulus: FIFO_DEPTH=4, spike_ready=0, 6 fires.
  - Required: 4 events held, drop_count=2, head stable. Then spike_ready=1 drains 4 events in order with correct timestamps.
- Full with simultaneous pop+push:
  - Stimulus: FIFO full, spike_ready=1 in the same cycle as a fire.
  - Required: no drop, occupancy stays 4.
- Timestamp wrap and reset:
  - Stimulus: TS_W=4, 16 ticks, then fire; then assert rst during REFRACT with a non-empty FIFO.
  - Required: the fire carries timestamp 0. On rst, all outputs return to 0 immediately, spike_valid=0, and state is ARMED after release.
